// File: rtl/axis_pkt_loopback_fifo_if.sv
// rtl/axis_pkt_loopback_fifo_if.sv - AXI4-Stream bundle with master/slave views for the packet loopback FIFO
interface axis_pkt_loopback_fifo_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int DEST_W = 4
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;
    logic [ID_W-1:0]       tid;
    logic [DEST_W-1:0]     tdest;

    modport master (output tvalid, tdata, tkeep, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_pkt_loopback_fifo.sv
// rtl/axis_pkt_loopback_fifo.sv - store-and-forward AXI4-Stream packet FIFO with whole-packet drop
// Optional drop statistics (drop_count, overflow) enabled by AXIS_PKT_FIFO_STATS_EN.
module axis_pkt_loopback_fifo #(
    parameter int DATA_W     = 32,
    parameter int ID_W       = 4,
    parameter int DEST_W     = 4,
    parameter int DEPTH      = 512,
    parameter int SWAP_ROUTE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    axis_pkt_loopback_fifo_if.slave  s_axis,
    axis_pkt_loopback_fifo_if.master m_axis,
    output logic [$clog2(DEPTH):0]   data_count,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic [31:0]              drop_count,
    output logic                     overflow
);
    localparam int AW       = $clog2(DEPTH);
    localparam int KEEP_W   = DATA_W / 8;
    localparam int LAST_BIT = ID_W + DEST_W;
    localparam int EW       = DATA_W + KEEP_W + 1 + ID_W + DEST_W;
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_VALID} rd_state_t;

    logic [EW-1:0] mem [DEPTH];

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   wr_commit_q, wr_commit_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   pkt_cnt_q, pkt_cnt_d;
    logic          rdy_q, rdy_d;
    logic          drop_q, drop_d;
    logic [EW-1:0] out_q, out_d;
    rd_state_t     state_q, state_d;

    logic          beat_hs, full, wr_en, commit;
    logic          rd_hs, rd_pkt_done, load;
    logic [AW:0]   used;
    logic [AW-1:0] rd_addr;

    assign rdy_d          = 1'b1;
    assign s_axis.tready  = rdy_q;
    assign beat_hs        = s_axis.tvalid & rdy_q;
    // Occupancy counts the speculative (uncommitted) beats too, so a packet can never outgrow the buffer.
    assign used           = wr_ptr_q - rd_ptr_q;
    assign full           = (used == FULL_LVL);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        drop_d      = drop_q;
        wr_en       = 1'b0;
        commit      = 1'b0;
        if (beat_hs) begin
            if (drop_q) begin
                if (s_axis.tlast) drop_d = 1'b0;
            end else if (full) begin
                wr_ptr_d = wr_commit_q;
                drop_d   = ~s_axis.tlast;
            end else begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + ONE;
                if (s_axis.tlast) begin
                    wr_commit_d = wr_ptr_q + ONE;
                    commit      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        load        = 1'b0;
        rd_addr     = rd_ptr_q[AW-1:0];
        rd_hs       = (state_q == RD_VALID) & m_axis.tready;
        rd_pkt_done = rd_hs & out_q[LAST_BIT];
        unique case (state_q)
            RD_IDLE:  if (pkt_cnt_q != '0) state_d = RD_FETCH;
            RD_FETCH: begin
                load    = 1'b1;
                state_d = RD_VALID;
            end
            RD_VALID: begin
                if (m_axis.tready) begin
                    rd_ptr_d = rd_ptr_q + ONE;
                    // Only prefetch across a packet boundary when the next packet was committed earlier,
                    // so the read never races a write to the same entry.
                    if (!out_q[LAST_BIT] || (pkt_cnt_q > ONE)) begin
                        load    = 1'b1;
                        rd_addr = rd_ptr_d[AW-1:0];
                    end else begin
                        state_d = RD_IDLE;
                    end
                end
            end
            default:  state_d = RD_IDLE;
        endcase
        out_d = load ? mem[rd_addr] : out_q;
    end

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        unique case ({commit, rd_pkt_done})
            2'b10:   pkt_cnt_d = pkt_cnt_q + ONE;
            2'b01:   pkt_cnt_d = pkt_cnt_q - ONE;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tid, s_axis.tdest};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            pkt_cnt_q   <= '0;
            rdy_q       <= 1'b0;
            drop_q      <= 1'b0;
            out_q       <= '0;
            state_q     <= RD_IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            rdy_q       <= rdy_d;
            drop_q      <= drop_d;
            out_q       <= out_d;
            state_q     <= state_d;
        end
    end

    assign m_axis.tvalid = (state_q == RD_VALID);
    assign m_axis.tdata  = out_q[EW-1 -: DATA_W];
    assign m_axis.tkeep  = out_q[LAST_BIT+1 +: KEEP_W];
    assign m_axis.tlast  = out_q[LAST_BIT];

    generate
        if (SWAP_ROUTE != 0) begin : g_swap
            assign m_axis.tid   = out_q[DEST_W-1:0];
            assign m_axis.tdest = out_q[LAST_BIT-1 -: ID_W];
        end else begin : g_pass
            assign m_axis.tid   = out_q[LAST_BIT-1 -: ID_W];
            assign m_axis.tdest = out_q[DEST_W-1:0];
        end
    endgenerate

    assign data_count = wr_commit_q - rd_ptr_q;
    assign pkt_count  = pkt_cnt_q;

`ifdef AXIS_PKT_FIFO_STATS_EN
    logic        ovf_evt;
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic        ovf_q, ovf_d;

    assign ovf_evt = beat_hs & ~drop_q & full;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_evt && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 32'd1;
        ovf_d = ovf_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign drop_count = drop_cnt_q;
    assign overflow   = ovf_q;
`else
    assign drop_count = '0;
    assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_axis_pkt_loopback_fifo.sv
// tb/tb_axis_pkt_loopback_fifo.sv - randomized self-checking bench for axis_pkt_loopback_fifo
module tb_axis_pkt_loopback_fifo;
    localparam int DEPTH = 16;
`ifdef AXIS_PKT_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst;
    logic [4:0]  data_count, pkt_count, data_count1, pkt_count1;
    logic [31:0] drop_count, drop_count1;
    logic        ovf0, ovf1;

    axis_pkt_loopback_fifo_if #(.DATA_W(32), .ID_W(4), .DEST_W(4)) s0();
    axis_pkt_loopback_fifo_if #(.DATA_W(32), .ID_W(4), .DEST_W(4)) m0();
    axis_pkt_loopback_fifo_if #(.DATA_W(32), .ID_W(4), .DEST_W(4)) s1();
    axis_pkt_loopback_fifo_if #(.DATA_W(32), .ID_W(4), .DEST_W(4)) m1();

    assign s1.tvalid = s0.tvalid;
    assign s1.tdata  = s0.tdata;
    assign s1.tkeep  = s0.tkeep;
    assign s1.tlast  = s0.tlast;
    assign s1.tid    = s0.tid;
    assign s1.tdest  = s0.tdest;
    assign m1.tready = m0.tready;

    axis_pkt_loopback_fifo #(.DATA_W(32), .ID_W(4), .DEST_W(4), .DEPTH(DEPTH), .SWAP_ROUTE(0)) dut (
        .clk(clk), .rst(rst), .s_axis(s0), .m_axis(m0),
        .data_count(data_count), .pkt_count(pkt_count), .drop_count(drop_count), .overflow(ovf0));

    axis_pkt_loopback_fifo #(.DATA_W(32), .ID_W(4), .DEST_W(4), .DEPTH(DEPTH), .SWAP_ROUTE(1)) dut_swap (
        .clk(clk), .rst(rst), .s_axis(s1), .m_axis(m1),
        .data_count(data_count1), .pkt_count(pkt_count1), .drop_count(drop_count1), .overflow(ovf1));

    int n_checks = 0;
    int n_errors = 0;
    int pushed = 0;
    int popped = 0;
    int exp_drop = 0;
    int exp_ovf = 0;
    int ovf_seen = 0;
    int rdy_mode = 0;
    logic [44:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        m0.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m0.tready = 1'b0;
                1:       m0.tready = 1'b1;
                default: m0.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: every output handshake must match the oldest accepted beat.
    always @(negedge clk) begin
        logic [44:0] e;
        if (!rst && ovf0) ovf_seen++;
        if (!rst && m0.tvalid && m0.tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("tdata", m0.tdata, e[44:13]);
                check("tkeep", m0.tkeep, e[12:9]);
                check("tlast", m0.tlast, e[8]);
                check("tid", m0.tid, e[7:4]);
                check("tdest", m0.tdest, e[3:0]);
                check("swap_tvalid", m1.tvalid, 1'b1);
                check("swap_tid", m1.tid, e[3:0]);
                check("swap_tdest", m1.tdest, e[7:4]);
                popped++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A packet is kept iff it fits into the space not occupied by committed, unread beats.
    task automatic send_pkt(input int len, input logic [3:0] tid, input logic [3:0] tdest, input bit fixed);
        logic [31:0] d;
        logic [3:0]  k;
        bit          fits;
        fits = (pushed - popped + len <= DEPTH);
        for (int i = 0; i < len; i++) begin
            d = fixed ? 32'h11 * (i + 1) : $urandom;
            k = fixed ? 4'hF : 4'($urandom_range(1, 15));
            s0.tvalid = 1'b1;
            s0.tdata  = d;
            s0.tkeep  = k;
            s0.tlast  = (i == len - 1);
            s0.tid    = tid;
            s0.tdest  = tdest;
            if (fits) exp_q.push_back({d, k, (i == len - 1), tid, tdest});
            @(posedge clk);
            #1;
        end
        s0.tvalid = 1'b0;
        s0.tlast  = 1'b0;
        if (fits) pushed += len;
        else begin
            exp_drop++;
            exp_ovf++;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        cycles(3);
    endtask

    initial begin
        int len;
        int guard;
        rst = 1'b1;
        s0.tvalid = 1'b0; s0.tdata = '0; s0.tkeep = '0; s0.tlast = 1'b0; s0.tid = '0; s0.tdest = '0;
        #12;
        check("rst_tready", s0.tready, 1'b0);
        check("rst_tvalid", m0.tvalid, 1'b0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_data_count", data_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_overflow", ovf0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("tready_before_edge", s0.tready, 1'b0);
        @(negedge clk);
        check("tready_after_edge", s0.tready, 1'b1);

        // Latency, contiguity and routing of a 3-beat packet.
        rdy_mode = 1;
        cycles(2);
        send_pkt(3, 4'd2, 4'd5, 1'b1);
        @(negedge clk); check("lat_n0", m0.tvalid, 1'b0);
        @(negedge clk); check("lat_n1", m0.tvalid, 1'b0);
        @(negedge clk); check("lat_n2", m0.tvalid, 1'b1);
        @(negedge clk); check("beat2_valid", m0.tvalid, 1'b1);
        @(negedge clk); check("beat3_valid", m0.tvalid, 1'b1);
        @(negedge clk); check("after_valid", m0.tvalid, 1'b0);
        wait_drain();

        // Exactly-DEPTH packet kept, following 1-beat packet dropped.
        rdy_mode = 0;
        cycles(2);
        send_pkt(DEPTH, 4'd1, 4'd3, 1'b0);
        send_pkt(1, 4'd4, 4'd6, 1'b0);
        cycles(3);
        check("full_pkt_count", pkt_count, 1);
        check("full_data_count", data_count, DEPTH);
        check("full_drop_count", drop_count, STATS ? exp_drop : 0);
        check("full_ovf_pulses", ovf_seen, STATS ? exp_ovf : 0);
        rdy_mode = 1;
        wait_drain();

        // Oversized packet dropped whole, then a small packet passes intact.
        rdy_mode = 0;
        cycles(2);
        send_pkt(DEPTH + 4, 4'd7, 4'd8, 1'b0);
        cycles(3);
        check("big_pkt_count", pkt_count, 0);
        check("big_data_count", data_count, 0);
        check("big_drop_count", drop_count, STATS ? exp_drop : 0);
        send_pkt(2, 4'd9, 4'd10, 1'b0);
        cycles(2);
        check("small_pkt_count", pkt_count, 1);
        check("small_data_count", data_count, 2);
        rdy_mode = 1;
        wait_drain();
        check("ovf_pulses", ovf_seen, STATS ? exp_ovf : 0);

        // Random backpressure; the source only sends when the packet fits with a one-beat margin.
        rdy_mode = 2;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 8);
            guard = 0;
            while ((pushed - popped + len > DEPTH - 1) && guard < 500) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 500) check("space_timeout", 64'd1, 64'd0);
            send_pkt(len, 4'($urandom), 4'($urandom), 1'b0);
            cycles($urandom_range(0, 2));
        end
        rdy_mode = 1;
        wait_drain();
        check("rand_drop_count", drop_count, STATS ? exp_drop : 0);

        // Reset in the middle of a 5-beat packet.
        for (int i = 0; i < 3; i++) begin
            s0.tvalid = 1'b1; s0.tdata = 32'hDEAD0000 + i; s0.tkeep = 4'hF; s0.tlast = 1'b0;
            @(posedge clk); #1;
        end
        #1;
        rst = 1'b1;
        s0.tvalid = 1'b0;
        #1;
        check("mid_rst_tready", s0.tready, 1'b0);
        check("mid_rst_tvalid", m0.tvalid, 1'b0);
        check("mid_rst_pkt_count", pkt_count, 0);
        check("mid_rst_data_count", data_count, 0);
        check("mid_rst_drop_count", drop_count, 0);
        cycles(2);
        rst = 1'b0;
        pushed = 0; popped = 0; exp_drop = 0;
        exp_q.delete();
        @(negedge clk); check("rel_tready_lo", s0.tready, 1'b0);
        @(negedge clk); check("rel_tready_hi", s0.tready, 1'b1);
        cycles(1);
        send_pkt(5, 4'd11, 4'd12, 1'b0);
        wait_drain();
        check("final_pkt_count", pkt_count, 0);
        check("final_data_count", data_count, 0);
        check("final_drop_count", drop_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
